// File: rtl/mac_accumulator.sv
// Sequential signed fixed-point dot product: VEC_LEN (x, w) pairs in, one rescaled, saturated word out.
// Optional macro ROUND_EN: round half toward +inf before saturation instead of truncating.
module mac_accumulator #(
  parameter int INPUT_BITS  = 16,
  parameter int OUTPUT_BITS = 16,
  parameter int FRAC_BITS   = 8,
  parameter int ACC_BITS    = 40,
  parameter int VEC_LEN     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_BITS-1:0]  in_x,
  input  logic [INPUT_BITS-1:0]  in_w,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUTPUT_BITS-1:0] out_y
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid/data hold stable until that edge, and ready never depends on valid.

  localparam int CNT_W = $clog2(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);
  localparam logic signed [ACC_BITS:0] SAT_MAX =
    {{(ACC_BITS - OUTPUT_BITS + 2){1'b0}}, {(OUTPUT_BITS - 1){1'b1}}};
  localparam logic signed [ACC_BITS:0] SAT_MIN =
    {{(ACC_BITS - OUTPUT_BITS + 2){1'b1}}, {(OUTPUT_BITS - 1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                   state, state_nxt;
  logic signed [ACC_BITS-1:0] acc, acc_nxt;
  logic signed [ACC_BITS-1:0] x_ext, w_ext, prod, sum;
  logic signed [ACC_BITS:0]   sum_wide, rounded, scaled;
  logic [CNT_W-1:0]         count, count_nxt;
  logic [OUTPUT_BITS-1:0]   sat_y, y_nxt;
  logic                     valid_nxt;
  logic                     accept;

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid & in_ready;

  // Operands are widened first so the product is computed at full precision.
  assign x_ext = {{(ACC_BITS - INPUT_BITS){in_x[INPUT_BITS-1]}}, in_x};
  assign w_ext = {{(ACC_BITS - INPUT_BITS){in_w[INPUT_BITS-1]}}, in_w};
  assign prod  = x_ext * w_ext;
  assign sum   = acc + prod;

  // One guard bit keeps the rounding add from wrapping at the top of the range.
  assign sum_wide = {sum[ACC_BITS-1], sum};
`ifdef ROUND_EN
  localparam logic signed [ACC_BITS:0] HALF = {{ACC_BITS{1'b0}}, 1'b1} << (FRAC_BITS - 1);
  assign rounded = sum_wide + HALF;
`else
  assign rounded = sum_wide;
`endif
  assign scaled = rounded >>> FRAC_BITS;

  always_comb begin
    sat_y = scaled[OUTPUT_BITS-1:0];
    if (scaled > SAT_MAX)
      sat_y = {1'b0, {(OUTPUT_BITS - 1){1'b1}}};
    else if (scaled < SAT_MIN)
      sat_y = {1'b1, {(OUTPUT_BITS - 1){1'b0}}};
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    y_nxt     = out_y;
    valid_nxt = out_valid;
    case (state)
      ACCUM: begin
        if (accept) begin
          if (count == LAST) begin
            y_nxt     = sat_y;
            valid_nxt = 1'b1;
            acc_nxt   = '0;
            count_nxt = '0;
            state_nxt = HOLD;
          end else begin
            acc_nxt   = sum;
            count_nxt = count + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          valid_nxt = 1'b0;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      out_y     <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      count     <= count_nxt;
      out_y     <= y_nxt;
      out_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator at VEC_LEN=4: table vectors, random vectors against a small model,
// output back-pressure and mid-vector reset sequences.
module tb_mac_accumulator;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_w;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;

  int total = 0;
  int bad   = 0;
  int pushed = 0;
  int got    = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [N-1:0][15:0] x;
    logic [N-1:0][15:0] w;
    logic [15:0]        y;
  } vec_t;

  vec_t tbl[5];

  mac_accumulator #(.VEC_LEN(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: exact signed sum, then shift, optional rounding, saturation.
  function automatic logic [15:0] model(input logic [N-1:0][15:0] xs, input logic [N-1:0][15:0] ws);
    longint s = 0;
    for (int i = 0; i < N; i++)
      s += longint'($signed(xs[i])) * longint'($signed(ws[i]));
`ifdef ROUND_EN
    s += 128;
`endif
    s = s >>> 8;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic send_pair(input logic [15:0] x, input logic [15:0] w);
    int cyc = 0;
    in_valid = 1'b1;
    in_x = x;
    in_w = w;
    while (!in_ready) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 50) begin
        total++; bad++;
        $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [N-1:0][15:0] xs, input logic [N-1:0][15:0] ws,
                          input logic [15:0] y);
    exp_q.push_back(y);
    pushed++;
    for (int i = 0; i < N; i++) send_pair(xs[i], ws[i]);
  endtask

  // Scoreboard: a result is consumed on the edge after a negedge where valid & ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_output: got %h expected none", out_y);
      end else begin
        check("out_y", out_y, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [N-1:0][15:0] rx, rw;
    int cyc;

    tbl[0] = '{x: {4{16'h0100}}, w: {4{16'h0100}}, y: 16'h0400};
    tbl[1] = '{x: {4{16'hFF00}}, w: {4{16'h0200}}, y: 16'hF800};
    tbl[2] = '{x: {4{16'h7FFF}}, w: {4{16'h7FFF}}, y: 16'h7FFF};
    tbl[3] = '{x: {4{16'h8000}}, w: {4{16'h7FFF}}, y: 16'h8000};
`ifdef ROUND_EN
    tbl[4] = '{x: {16'h0000, 16'h0000, 16'h0000, 16'h0001},
               w: {16'h0000, 16'h0000, 16'h0000, 16'h0080}, y: 16'h0001};
`else
    tbl[4] = '{x: {16'h0000, 16'h0000, 16'h0000, 16'h0001},
               w: {16'h0000, 16'h0000, 16'h0000, 16'h0080}, y: 16'h0000};
`endif

    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_w = '0;
    out_ready = 1'b1;
    #12;
    check("reset_out_valid", {15'd0, out_valid}, 16'd0);
    check("reset_out_y", out_y, 16'h0000);
    check("reset_in_ready", {15'd0, in_ready}, 16'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table vectors; out_valid must be up right after the last accept.
    for (int t = 0; t < 5; t++) begin
      send_vec(tbl[t].x, tbl[t].w, tbl[t].y);
      check("latency_out_valid", {15'd0, out_valid}, 16'd1);
    end

    // Random vectors checked against the model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        if (r < 3) begin
          rx[i] = 16'($signed(12'($urandom_range(0, 4095))));
          rw[i] = 16'($signed(12'($urandom_range(0, 4095))));
        end else begin
          rx[i] = 16'($urandom_range(0, 65535));
          rw[i] = 16'($urandom_range(0, 65535));
        end
      end
      send_vec(rx, rw, model(rx, rw));
    end

    // Back-pressure: result held and input blocked while out_ready is low.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_vec(tbl[0].x, tbl[0].w, tbl[0].y);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_out_y", out_y, 16'h0400);
      check("hold_in_ready", {15'd0, in_ready}, 16'd0);
      check("hold_out_valid", {15'd0, out_valid}, 16'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", {15'd0, in_ready}, 16'd1);
    check("release_out_valid", {15'd0, out_valid}, 16'd0);

    // Reset mid-vector discards the partial sum and clears the held output.
    send_pair(16'h0100, 16'h0100);
    send_pair(16'h0100, 16'h0100);
    #3 rst = 1'b1;
    #1;
    check("midreset_out_valid", {15'd0, out_valid}, 16'd0);
    check("midreset_out_y", out_y, 16'h0000);
    check("midreset_in_ready", {15'd0, in_ready}, 16'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    send_vec(tbl[0].x, tbl[0].w, tbl[0].y);

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    total++;
    if (got != pushed) begin
      bad++;
      $display("FAIL output_count: got %0d expected %0d", got, pushed);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
